// File: rtl/alu_add9.sv
// alu_add9: WIDTH-bit adder with a WIDTH+1-bit lossless result.
// mode=0 adds the operands as unsigned values, mode=1 adds them as two's complement.
// `out` is purely combinational; a registered copy of the result and its flags
// feeds pipelined consumers with exactly one cycle of latency.
module alu_add9 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   out,
    output logic [WIDTH:0]   out_q,
    output logic             carry_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             neg_q
);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic           carry;
    logic           ovf;
    logic           zero;
    logic           neg;

    // Extend both operands by one bit (sign bit in signed mode, zero otherwise)
    // so the sum can never wrap, then derive the status flags from the result.
    always_comb begin
        ext_a = {mode & in_a[WIDTH-1], in_a};
        ext_b = {mode & in_b[WIDTH-1], in_b};
        out   = ext_a + ext_b;
        carry = ~mode & out[WIDTH];
        // Signed: the result needs the extra bit when its top two bits differ.
        ovf   = mode ? (out[WIDTH] != out[WIDTH-1]) : out[WIDTH];
        zero  = (out == '0);
        neg   = mode & out[WIDTH];
    end

    // Capture result and flags every edge; reset clears everything, including zero_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            out_q   <= out;
            carry_q <= carry;
            ovf_q   <= ovf;
            zero_q  <= zero;
            neg_q   <= neg;
        end
    end

endmodule

// File: tb/tb_alu_add9.sv
// Testbench for alu_add9: combinational `out` is checked right after each input
// change; the expected registered response is queued and compared by a monitor
// one cycle later.
module tb_alu_add9;

    typedef struct packed {
        logic [8:0] q;
        logic       c;
        logic       o;
        logic       z;
        logic       n;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [8:0] out;
    logic [8:0] out_q;
    logic       carry_q;
    logic       ovf_q;
    logic       zero_q;
    logic       neg_q;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_add9 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .in_a    (in_a),
        .in_b    (in_b),
        .out     (out),
        .out_q   (out_q),
        .carry_q (carry_q),
        .ovf_q   (ovf_q),
        .zero_q  (zero_q),
        .neg_q   (neg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic [8:0] exp);
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s: out got %h expected %h", name, out, exp);
        end
    endtask

    // Drive one vector at the falling edge, check `out`, queue registered expectation.
    task automatic step(input logic r, input logic m, input logic [7:0] a,
                        input logic [7:0] b, input logic [8:0] eo,
                        input logic c, input logic o, input logic z, input logic n);
        exp_t e;
        @(negedge clk);
        rst  = r;
        mode = m;
        in_a = a;
        in_b = b;
        #1;
        check_out($sformatf("comb m=%0b a=%h b=%h", m, a, b), eo);
        if (r) e = '0;
        else   e = '{q: eo, c: c, o: o, z: z, n: n};
        sb.push_back(e);
    endtask

    // Monitor: one registered result is due after every rising edge that had a queued vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({out_q, carry_q, ovf_q, zero_q, neg_q} !== e) begin
                    errors++;
                    $display("FAIL reg: got out_q=%h c=%b o=%b z=%b n=%b expected out_q=%h c=%b o=%b z=%b n=%b",
                             out_q, carry_q, ovf_q, zero_q, neg_q, e.q, e.c, e.o, e.z, e.n);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;

        // Reset state: zero_q must come out of reset as 0 even though out == 0.
        step(1, 0, 8'h00, 8'h00, 9'h000, 0, 0, 0, 0);
        step(1, 0, 8'h00, 8'h00, 9'h000, 0, 0, 0, 0);

        //    rst m  a      b      out     c  o  z  n
        step(0, 0, 8'hFF, 8'h01, 9'h100, 1, 1, 0, 0);
        step(0, 0, 8'hC8, 8'h64, 9'h12C, 1, 1, 0, 0);
        step(0, 0, 8'h00, 8'h00, 9'h000, 0, 0, 1, 0);
        step(0, 1, 8'h80, 8'h80, 9'h100, 0, 1, 0, 1);
        step(0, 1, 8'h7F, 8'h7F, 9'h0FE, 0, 1, 0, 0);
        step(0, 1, 8'hFF, 8'hFF, 9'h1FE, 0, 0, 0, 1);
        step(0, 1, 8'hFF, 8'h01, 9'h000, 0, 0, 1, 0);
        step(0, 0, 8'h12, 8'h34, 9'h046, 0, 0, 0, 0);
        step(0, 1, 8'h10, 8'hE0, 9'h1F0, 0, 0, 0, 1);
        step(0, 0, 8'h7F, 8'h80, 9'h0FF, 0, 0, 0, 0);
        step(0, 1, 8'h80, 8'h7F, 9'h1FF, 0, 0, 0, 1);

        // Mode toggle without a clock edge: signed -1 + 1 = 0, then unsigned 255 + 1 = 256.
        @(negedge clk);
        rst  = 1'b0;
        mode = 1'b1;
        in_a = 8'hFF;
        in_b = 8'h01;
        #1;
        check_out("toggle signed", 9'h000);
        mode = 1'b0;
        #2;
        check_out("toggle unsigned", 9'h100);
        sb.push_back('{q: 9'h100, c: 1'b1, o: 1'b1, z: 1'b0, n: 1'b0});

        // Mid-stream reset: registers clear while `out` keeps showing the sum.
        step(0, 0, 8'hC8, 8'h64, 9'h12C, 1, 1, 0, 0);
        step(1, 1, 8'h80, 8'h80, 9'h100, 0, 1, 0, 1);
        step(0, 1, 8'h80, 8'h80, 9'h100, 0, 1, 0, 1);
        step(0, 1, 8'h10, 8'hE0, 9'h1F0, 0, 0, 0, 1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
